// File: rtl/midi_voice_allocator.sv
// rtl/midi_voice_allocator.sv - polyphonic MIDI note-to-voice allocator with oldest-voice stealing
module midi_voice_allocator #(
    parameter int VOICES  = 4,
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0,
    parameter int STEAL   = 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [23:0]           MIDI_MSG,
    input  logic                  MIDI_MSG_RDY,
    output logic [VOICES-1:0]     VOICE_GATE,
    output logic [7*VOICES-1:0]   VOICE_NOTE,
    output logic [7*VOICES-1:0]   VOICE_VEL,
    output logic [VOICES-1:0]     VOICE_TRIG,
    output logic [6:0]            LAST_NOTE,
    output logic                  LAST_VALID
);

    localparam int RW = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       msg_ok;
    logic       is_on;
    logic       is_off;
    logic       is_all_off;

    logic [RW-1:0] rank [VOICES];
    logic [RW-1:0] rank_n [VOICES];

    logic          hit_found;
    logic [RW-1:0] hit_idx;
    logic          free_found;
    logic [RW-1:0] free_idx;
    logic          steal_found;
    logic [RW-1:0] steal_idx;
    logic [RW-1:0] best_rank;
    logic          assign_en;
    logic [RW-1:0] assign_idx;
    logic [RW-1:0] assign_rank;

    logic [VOICES-1:0]   gate_n;
    logic [7*VOICES-1:0] note_n;
    logic [7*VOICES-1:0] vel_n;
    logic [VOICES-1:0]   trig_n;
    logic [6:0]          last_note_n;

    assign status = MIDI_MSG[23:16];
    assign data1  = MIDI_MSG[15:8];
    assign data2  = MIDI_MSG[7:0];

    assign msg_ok = MIDI_MSG_RDY
                  && ((OMNI != 0) || (status[3:0] == 4'(CHANNEL)))
                  && !data1[7] && !data2[7];

    // Note On with zero velocity is the running-status form of Note Off.
    assign is_on      = msg_ok && (status[7:4] == 4'h9) && (data2 != 8'h00);
    assign is_off     = msg_ok && ((status[7:4] == 4'h8)
                      || ((status[7:4] == 4'h9) && (data2 == 8'h00)));
    assign is_all_off = msg_ok && (status[7:4] == 4'hB) && (data1 == 8'h7B);

    always_comb begin
        hit_found   = 1'b0;
        hit_idx     = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        steal_found = 1'b0;
        steal_idx   = '0;
        best_rank   = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (VOICE_GATE[i] && (VOICE_NOTE[7*i +: 7] == data1[6:0])) begin
                hit_found = 1'b1;
                hit_idx   = RW'(i);
            end
        end
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (!VOICE_GATE[i]) begin
                free_found = 1'b1;
                free_idx   = RW'(i);
            end
        end
        for (int i = 0; i < VOICES; i++) begin
            if (VOICE_GATE[i] && (!steal_found || (rank[i] > best_rank))) begin
                steal_found = 1'b1;
                steal_idx   = RW'(i);
                best_rank   = rank[i];
            end
        end
    end

    always_comb begin
        assign_en  = 1'b0;
        assign_idx = '0;
        if (is_on) begin
            if (hit_found) begin
                assign_en  = 1'b1;
                assign_idx = hit_idx;
            end else if (free_found) begin
                assign_en  = 1'b1;
                assign_idx = free_idx;
            end else if ((STEAL != 0) && steal_found) begin
                assign_en  = 1'b1;
                assign_idx = steal_idx;
            end
        end
        assign_rank = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (RW'(i) == assign_idx) begin
                assign_rank = rank[i];
            end
        end
    end

    always_comb begin
        gate_n      = VOICE_GATE;
        note_n      = VOICE_NOTE;
        vel_n       = VOICE_VEL;
        trig_n      = '0;
        last_note_n = LAST_NOTE;
        for (int i = 0; i < VOICES; i++) begin
            rank_n[i] = rank[i];
        end
        if (assign_en) begin
            last_note_n = data1[6:0];
            for (int i = 0; i < VOICES; i++) begin
                if (RW'(i) == assign_idx) begin
                    gate_n[i]        = 1'b1;
                    trig_n[i]        = 1'b1;
                    note_n[7*i +: 7] = data1[6:0];
                    vel_n[7*i +: 7]  = data2[6:0];
                    rank_n[i]        = '0;
                end else if (rank[i] < assign_rank) begin
                    // Voices newer than the assigned one age by one step.
                    rank_n[i] = rank[i] + 1'b1;
                end
            end
        end
        if (is_off) begin
            for (int i = 0; i < VOICES; i++) begin
                if (VOICE_GATE[i] && (VOICE_NOTE[7*i +: 7] == data1[6:0])) begin
                    gate_n[i] = 1'b0;
                end
            end
        end
        if (is_all_off) begin
            gate_n = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            VOICE_GATE <= '0;
            VOICE_NOTE <= '0;
            VOICE_VEL  <= '0;
            VOICE_TRIG <= '0;
            LAST_NOTE  <= '0;
            LAST_VALID <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                rank[i] <= RW'(i);
            end
        end else begin
            VOICE_GATE <= gate_n;
            VOICE_NOTE <= note_n;
            VOICE_VEL  <= vel_n;
            VOICE_TRIG <= trig_n;
            LAST_NOTE  <= last_note_n;
            LAST_VALID <= |gate_n;
            for (int i = 0; i < VOICES; i++) begin
                rank[i] <= rank_n[i];
            end
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb/tb_midi_voice_allocator.sv - directed plus random check of four allocator configurations against a recency-list model
module tb_midi_voice_allocator;

    logic        CLK  = 1'b0;
    logic        nRST = 1'b1;
    logic        RDY  = 1'b0;
    logic [23:0] MSG  = '0;

    logic [3:0]  g0, t0, g1, t1, g2, t2;
    logic [27:0] n0, v0, n1, v1, n2, v2;
    logic [6:0]  ln0, ln1, ln2, ln3, n3, v3;
    logic        lv0, lv1, lv2, lv3;
    logic [0:0]  g3, t3;

    int total = 0;
    int bad   = 0;

    int nv  [4] = '{4, 4, 4, 1};
    int chn [4] = '{0, 0, 0, 3};
    int omn [4] = '{0, 1, 0, 0};
    int stl [4] = '{1, 1, 0, 1};

    bit         mg   [4][8];
    bit         mt   [4][8];
    logic [6:0] mn   [4][8];
    logic [6:0] mvl  [4][8];
    int         mord [4][8];
    logic [6:0] mlast[4];

    always #5 CLK = ~CLK;

    midi_voice_allocator #(.VOICES(4), .CHANNEL(0), .OMNI(0), .STEAL(1)) dut0 (
        .CLK(CLK), .nRST(nRST), .MIDI_MSG(MSG), .MIDI_MSG_RDY(RDY),
        .VOICE_GATE(g0), .VOICE_NOTE(n0), .VOICE_VEL(v0), .VOICE_TRIG(t0),
        .LAST_NOTE(ln0), .LAST_VALID(lv0));
    midi_voice_allocator #(.VOICES(4), .CHANNEL(0), .OMNI(1), .STEAL(1)) dut1 (
        .CLK(CLK), .nRST(nRST), .MIDI_MSG(MSG), .MIDI_MSG_RDY(RDY),
        .VOICE_GATE(g1), .VOICE_NOTE(n1), .VOICE_VEL(v1), .VOICE_TRIG(t1),
        .LAST_NOTE(ln1), .LAST_VALID(lv1));
    midi_voice_allocator #(.VOICES(4), .CHANNEL(0), .OMNI(0), .STEAL(0)) dut2 (
        .CLK(CLK), .nRST(nRST), .MIDI_MSG(MSG), .MIDI_MSG_RDY(RDY),
        .VOICE_GATE(g2), .VOICE_NOTE(n2), .VOICE_VEL(v2), .VOICE_TRIG(t2),
        .LAST_NOTE(ln2), .LAST_VALID(lv2));
    midi_voice_allocator #(.VOICES(1), .CHANNEL(3), .OMNI(0), .STEAL(1)) dut3 (
        .CLK(CLK), .nRST(nRST), .MIDI_MSG(MSG), .MIDI_MSG_RDY(RDY),
        .VOICE_GATE(g3), .VOICE_NOTE(n3), .VOICE_VEL(v3), .VOICE_TRIG(t3),
        .LAST_NOTE(ln3), .LAST_VALID(lv3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 4; m++) begin
            mlast[m] = '0;
            for (int i = 0; i < 8; i++) begin
                mg[m][i] = 0; mt[m][i] = 0; mn[m][i] = '0; mvl[m][i] = '0;
                mord[m][i] = i;
            end
        end
    endtask

    // mord[m][0] is the most recently assigned voice, mord[m][V-1] the oldest.
    task automatic model_msg(input int m, input logic [23:0] msg);
        logic [7:0] st, d1, d2;
        int v, p, nvx;
        st = msg[23:16]; d1 = msg[15:8]; d2 = msg[7:0];
        nvx = nv[m];
        if (omn[m] == 0 && int'(st[3:0]) != chn[m]) return;
        if (d1[7] || d2[7]) return;
        if (st[7:4] == 4'h9 && d2 != 0) begin
            v = -1;
            for (int i = 0; i < nvx; i++) if (mg[m][i] && mn[m][i] == d1[6:0]) v = i;
            if (v < 0) for (int i = nvx - 1; i >= 0; i--) if (!mg[m][i]) v = i;
            if (v < 0 && stl[m] != 0)
                for (int q = 0; q < nvx; q++) if (mg[m][mord[m][q]]) v = mord[m][q];
            if (v < 0) return;
            mg[m][v] = 1; mt[m][v] = 1; mn[m][v] = d1[6:0]; mvl[m][v] = d2[6:0];
            mlast[m] = d1[6:0];
            p = 0;
            for (int q = 0; q < nvx; q++) if (mord[m][q] == v) p = q;
            for (int q = p; q > 0; q--) mord[m][q] = mord[m][q-1];
            mord[m][0] = v;
        end else if (st[7:4] == 4'h8 || (st[7:4] == 4'h9 && d2 == 0)) begin
            for (int i = 0; i < nvx; i++) if (mg[m][i] && mn[m][i] == d1[6:0]) mg[m][i] = 0;
        end else if (st[7:4] == 4'hB && d1 == 8'h7B) begin
            for (int i = 0; i < nvx; i++) mg[m][i] = 0;
        end
    endtask

    task automatic check_all();
        logic [63:0] eg, en, ev, et, ag, an, av, at, aln, alv;
        for (int m = 0; m < 4; m++) begin
            eg = '0; en = '0; ev = '0; et = '0;
            for (int i = 0; i < nv[m]; i++) begin
                eg[i] = mg[m][i]; et[i] = mt[m][i];
                en[7*i +: 7] = mn[m][i]; ev[7*i +: 7] = mvl[m][i];
            end
            case (m)
                0: begin ag = {60'b0, g0}; an = {36'b0, n0}; av = {36'b0, v0}; at = {60'b0, t0};
                         aln = {57'b0, ln0}; alv = {63'b0, lv0}; end
                1: begin ag = {60'b0, g1}; an = {36'b0, n1}; av = {36'b0, v1}; at = {60'b0, t1};
                         aln = {57'b0, ln1}; alv = {63'b0, lv1}; end
                2: begin ag = {60'b0, g2}; an = {36'b0, n2}; av = {36'b0, v2}; at = {60'b0, t2};
                         aln = {57'b0, ln2}; alv = {63'b0, lv2}; end
                default: begin ag = {63'b0, g3}; an = {57'b0, n3}; av = {57'b0, v3}; at = {63'b0, t3};
                         aln = {57'b0, ln3}; alv = {63'b0, lv3}; end
            endcase
            chk($sformatf("gate%0d", m), ag, eg);
            chk($sformatf("note%0d", m), an, en);
            chk($sformatf("vel%0d", m), av, ev);
            chk($sformatf("trig%0d", m), at, et);
            chk($sformatf("last_note%0d", m), aln, {57'b0, mlast[m]});
            chk($sformatf("last_valid%0d", m), alv, {63'b0, (eg != 0)});
        end
    endtask

    task automatic step(input logic [23:0] m, input bit r);
        MSG = m; RDY = r;
        @(posedge CLK);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) mt[k][i] = 0;
            if (r) model_msg(k, m);
        end
        #1;
        check_all();
        RDY = 1'b0;
    endtask

    // Reset asserted between edges, with a valid message offered while held.
    task automatic do_reset();
        MSG = 24'h903C40; RDY = 1'b1; nRST = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge CLK);
        #1;
        check_all();
        RDY = 1'b0; nRST = 1'b1;
    endtask

    initial begin
        logic [3:0] hi, ch;
        logic [7:0] d1, d2;
        #1;
        do_reset();

        step(24'h903C40, 1);
        chk("t1_note0", {57'b0, n0[6:0]}, 64'h3C);
        chk("t1_trig", {60'b0, t0}, 64'h1);
        chk("t1_last", {57'b0, ln0}, 64'h3C);
        step(24'h000000, 0);
        chk("t1_trig_drop", {60'b0, t0}, 64'h0);

        do_reset();
        step(24'h903C40, 1); step(24'h903E40, 1); step(24'h904040, 1);
        step(24'h904140, 1); step(24'h904340, 1);
        chk("t2_gate_full", {60'b0, g0}, 64'hF);
        chk("t2_steal_trig", {60'b0, t0}, 64'h1);
        chk("t2_steal_note", {57'b0, n0[6:0]}, 64'h43);
        step(24'h803E00, 1);
        chk("t2_off62", {60'b0, g0}, 64'hD);

        do_reset();
        step(24'h903C40, 1); step(24'h903C00, 1);
        chk("t3_gate_off", {60'b0, g0}, 64'h0);
        chk("t3_note_kept", {57'b0, n0[6:0]}, 64'h3C);
        step(24'h903C40, 1); step(24'h903C7F, 1);
        chk("t3_retrig_vel", {57'b0, v0[6:0]}, 64'h7F);
        chk("t3_retrig_gate", {60'b0, g0}, 64'h1);
        chk("t3_retrig_trig", {60'b0, t0}, 64'h1);

        do_reset();
        step(24'h953C40, 1);
        chk("t4_ch5_ignored", {60'b0, g0}, 64'h0);
        chk("t4_ch5_omni", {60'b0, g1}, 64'h1);
        step(24'h90803C, 1);
        step(24'h903C40, 1); step(24'h903E40, 1); step(24'h904040, 1);
        chk("t4_three", {60'b0, g0}, 64'h7);
        step(24'hB07B00, 1);
        chk("t4_all_off", {60'b0, g0}, 64'h0);

        do_reset();
        step(24'h903C40, 1); step(24'h903E40, 1); step(24'h904040, 1);
        step(24'h904140, 1); step(24'h904640, 1);
        chk("t5_drop_last", {57'b0, ln2}, 64'h41);
        chk("t5_drop_trig", {60'b0, t2}, 64'h0);

        do_reset();
        step(24'h903C40, 1);
        chk("t6_trig_pre", {60'b0, t0}, 64'h1);
        nRST = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        nRST = 1'b1;
        step(24'h903040, 1);
        chk("t6_after_rst", {57'b0, n0[6:0]}, 64'h30);
        chk("t6_gate", {60'b0, g0}, 64'h1);

        do_reset();
        for (int k = 0; k < 450; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    hi = 4'h9;
                2:       hi = 4'h8;
                default: hi = 4'hB;
            endcase
            ch = 4'($urandom_range(0, 5));
            case ($urandom_range(0, 19))
                0:       d1 = 8'h7B;
                1:       d1 = 8'h80 | 8'($urandom_range(0, 127));
                default: d1 = 8'(60 + $urandom_range(0, 6));
            endcase
            case ($urandom_range(0, 19))
                0, 1, 2: d2 = 8'h00;
                3:       d2 = 8'h90;
                default: d2 = 8'($urandom_range(1, 127));
            endcase
            step({hi, ch, d1, d2}, $urandom_range(0, 3) != 0);
            if (k % 150 == 149) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
